// File: rtl/mem_req_pkg.sv
// Shared types and parameter defaults for the memory requester.
// The optional per-beat timeout is enabled by defining MEM_REQ_TIMEOUT_EN.
package mem_req_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } req_state_e;

endpackage

// File: rtl/mem_req_watchdog.sv
// Per-beat WAIT-cycle counter: cleared in SETUP, counts in WAIT, flags expiry
// on the TIMEOUT_CYC-th WAIT cycle. Only instantiated with MEM_REQ_TIMEOUT_EN.
module mem_req_watchdog
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of WAIT cycles already completed for this beat
    assign expired = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Single-port memory requester: accepts core read bursts / single writes and
// sequences SETUP/WAIT/RESP per beat. Optional timeout via MEM_REQ_TIMEOUT_EN.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              memory_w,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] o0,
    input  logic              memory_ready
);

    req_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] i0_q, i0_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              wd_expired;

`ifdef MEM_REQ_TIMEOUT_EN
    mem_req_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_SETUP),
        .en      (state_q == ST_WAIT),
        .expired (wd_expired)
    );
`else
    // No timeout: WAIT lasts until memory_ready, however long that takes
    assign wd_expired = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_last  = (state_q == ST_RESP) && ((cnt_q == 8'd0) || err_q);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign memory_w  = we_q;
    assign addr      = addr_q;
    assign i0        = i0_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        i0_d    = i0_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    i0_d    = req_wdata;
                    we_d    = req_we;
                    cnt_d   = req_we ? 8'd0 : req_len;
                    err_d   = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_WAIT;
            ST_WAIT: begin
                // memory_ready wins over a timeout landing on the same cycle
                if (memory_ready) begin
                    rdata_d = o0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if ((cnt_q == 8'd0) || err_q) begin
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            i0_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            i0_q    <= i0_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: vector table, random requests against
// a ROM-backed reference model, and hand sequences for latency/write/reset/timeout.
module tb_mem_requester;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 255;
`endif

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_last, rsp_err, memory_w, memory_ready;
    logic [15:0] rsp_rdata, addr, i0, o0;

    logic [15:0] mem [0:65535];
    int          rmode;     // 0 always ready, 1 random, 2 never, 3 manual
    logic        rnd_bit, man_rdy;
    int          n_tests, n_fail;

    mem_requester #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .memory_w(memory_w), .addr(addr), .i0(i0), .o0(o0), .memory_ready(memory_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign o0 = mem[addr];
    assign memory_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? rnd_bit :
                          (rmode == 2) ? 1'b0 : man_rdy;

    always @(negedge clk) rnd_bit = ($urandom % 3) == 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_idle", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one request at a negedge; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         input logic [7:0] len);
        wait_idle();
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Reference behaviour: beat i goes to (a+i) mod 2^16, reads return mem[],
    // writes are one beat regardless of len, last only on the final beat.
    task automatic run_req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           input logic [7:0] len, output int beats,
                           output logic [15:0] last_a);
        int          nexp, cyc;
        logic [15:0] ea;
        nexp   = we ? 1 : int'(len) + 1;
        beats  = 0;
        last_a = 16'hxxxx;
        cyc    = 0;
        issue(we, a, wd, len);
        while (beats < nexp && cyc < 8000) begin
            if (rsp_valid) begin
                ea = a + 16'(beats);
                chk("beat_addr", addr, ea);
                if (we) chk("beat_wdata", i0, wd);
                else    chk("beat_rdata", rsp_rdata, mem[ea]);
                chk("beat_last", rsp_last, (beats == nexp - 1) ? 1 : 0);
                chk("beat_err", rsp_err, 0);
                chk("beat_memw", memory_w, we);
                last_a = addr;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 8000) chk("req_timeout_budget", cyc, 0);
        chk("end_memw", memory_w, 0);
        chk("end_ready", req_ready, 1);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [15:0] wd;
        logic [7:0]  len;
        int          rm;
        int          exp_beats;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          beats, lat;
        logic [15:0] la;
        logic        we;
        logic [15:0] a;
        logic [7:0]  len;

        n_tests = 0; n_fail = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'hBEEF;

        vecs[0] = '{1'b0, 16'h0010, 16'h0000, 8'd0,   0, 1,   16'h0010};
        vecs[1] = '{1'b1, 16'h0020, 16'h1234, 8'd5,   1, 1,   16'h0020};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 8'd49,  1, 50,  16'h0031};
        vecs[3] = '{1'b0, 16'hFFFE, 16'h0000, 8'd3,   0, 4,   16'h0001};
        vecs[4] = '{1'b0, 16'h1234, 16'h0000, 8'd255, 1, 256, 16'h1333};
        vecs[5] = '{1'b1, 16'hFFFF, 16'hA5A5, 8'd7,   0, 1,   16'hFFFF};

        rmode = 0; man_rdy = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_addr", addr, 0);
        chk("rst_i0", i0, 0);
        chk("rst_memw", memory_w, 0);
        chk("rst_rsp", {rsp_valid, rsp_last, rsp_err}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read, ready on first WAIT: rsp_valid exactly 3 cycles after accept
        rmode = 0;
        issue(1'b0, 16'h0010, 16'h0, 8'd0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_latency", lat, 3);
        chk("rd_data", rsp_rdata, 16'hBEEF);
        chk("rd_last", rsp_last, 1);
        @(negedge clk);
        chk("rd_rdata_hold", rsp_rdata, 16'hBEEF);

        // Single write, ready after 4 WAIT cycles: strobe/addr/data stable throughout
        rmode = 3; man_rdy = 1'b0;
        issue(1'b1, 16'h0020, 16'h1234, 8'd0);
        for (int k = 0; k < 6; k++) begin
            chk("wr_hold", {memory_w, rsp_valid, addr, i0}, {1'b1, 1'b0, 16'h0020, 16'h1234});
            if (k == 5) man_rdy = 1'b1;
            @(negedge clk);
        end
        man_rdy = 1'b0;
        chk("wr_rsp", {rsp_valid, rsp_last, rsp_err, memory_w}, 4'b1101);
        @(negedge clk);
        chk("wr_idle", {memory_w, req_ready, rsp_valid}, 3'b010);

        for (int v = 0; v < 6; v++) begin
            rmode = vecs[v].rm;
            run_req(vecs[v].we, vecs[v].a, vecs[v].wd, vecs[v].len, beats, la);
            chk("vec_beats", beats, vecs[v].exp_beats);
            chk("vec_last_addr", la, vecs[v].exp_last);
        end

        for (int r = 0; r < 25; r++) begin
            we    = ($urandom % 3) == 0;
            a     = 16'($urandom);
            len   = 8'($urandom % 16);
            rmode = int'($urandom % 2);
            run_req(we, a, 16'($urandom), len, beats, la);
            chk("rnd_beats", beats, we ? 1 : int'(len) + 1);
        end

        // Reset during the WAIT of the second beat
        rmode = 3; man_rdy = 1'b1;
        issue(1'b0, 16'h0100, 16'h0, 8'd3);
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat0", rsp_valid, 1);
        @(negedge clk);
        man_rdy = 1'b0;
        @(negedge clk);
        chk("mid_pre_rst", {rsp_valid, addr}, {1'b0, 16'h0101});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {req_ready, memory_w, rsp_valid, rsp_last, rsp_err, addr, i0, rsp_rdata},
            {1'b1, 4'b0000, 16'h0, 16'h0, 16'h0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_quiet", {rsp_valid, memory_w}, 0);
        end
        rst_n = 1'b1;
        man_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_after_rel", {req_ready, rsp_valid, memory_w}, 3'b100);
        end

`ifdef MEM_REQ_TIMEOUT_EN
        // Memory never answers: error response after 8 WAIT cycles, burst aborted
        rmode = 2;
        issue(1'b0, 16'h0040, 16'h0, 8'd5);
        for (int k = 0; k < 9; k++) begin
            chk("to_wait", rsp_valid, 0);
            @(negedge clk);
        end
        chk("to_rsp", {rsp_valid, rsp_err, rsp_last}, 3'b111);
        @(negedge clk);
        chk("to_idle", {req_ready, rsp_valid}, 2'b10);

        // Ready arriving on the expiry cycle is a normal beat
        rmode = 3; man_rdy = 1'b0;
        issue(1'b0, 16'h0050, 16'h0, 8'd1);
        for (int k = 0; k < 9; k++) begin
            if (k == 8) man_rdy = 1'b1;
            @(negedge clk);
        end
        chk("to_prio", {rsp_valid, rsp_err, rsp_last}, 3'b100);
        chk("to_prio_data", rsp_rdata, mem[16'h0050]);
        man_rdy = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, max WAIT cycles per beat (used only with MEM_REQ_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: core request present.
REQ-007 SHALL have port req_ready, output, 1 bit: requester accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: start address.
REQ-010 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 SHALL have port req_len, input, 8 bits: read burst beats minus 1; ignored for writes.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle beat completion pulse.
REQ-013 SHALL have port rsp_rdata, output, DATA_W bits: read data of the beat.
REQ-014 SHALL have port rsp_last, output, 1 bit: final beat of the request.
REQ-015 SHALL have port rsp_err, output, 1 bit: beat aborted by timeout.
REQ-016 SHALL have port memory_w, output, 1 bit: write strobe to memory.
REQ-017 SHALL have port addr, output, ADDR_W bits: memory address.
REQ-018 SHALL have port i0, output, DATA_W bits: write data to memory.
REQ-019 SHALL have port o0, input, DATA_W bits: read data from memory.
REQ-020 SHALL have port memory_ready, input, 1 bit: memory access at current addr complete (level).

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, WAIT, RESP.
REQ-022 SHALL assert req_ready only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-023 SHALL, on acceptance, register addr=req_addr, i0=req_wdata, memory_w=req_we, and beat count=req_len (0 for writes), then go to SETUP.
REQ-024 SHALL ignore memory_ready in SETUP (bus turnaround) and go to WAIT after exactly one cycle.
REQ-025 SHALL hold addr, i0 and memory_w stable throughout SETUP and WAIT.
REQ-026 SHALL, in WAIT with memory_ready=1, capture o0 into rsp_rdata and go to RESP.
REQ-027 SHALL pulse rsp_valid for exactly the one RESP cycle; rsp_last=1 when beat count is 0.
REQ-028 SHALL, in RESP, return to IDLE with memory_w=0 if the beat was last; otherwise decrement the count, set addr=addr+1, and go to SETUP.
REQ-029 SHALL give a minimum latency of 3 cycles from acceptance to rsp_valid (accept edge, SETUP, WAIT with ready, RESP).
REQ-030 SHALL wrap addr modulo 2^ADDR_W (0xFFFF+1 -> 0x0000) without error.
REQ-031 SHALL hold rsp_rdata until the next captured beat; for writes, rsp_rdata is don't-care.
REQ-032 SHALL not provide response back-pressure; the core must consume rsp_valid whenever it occurs.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, req_ready=1, addr=0, i0=0, memory_w=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, rsp_err=0, and beat/timeout counters=0.
REQ-034 SHALL, on reset mid-burst, drop the access immediately with no response emitted and no further memory_w.

Configuration
REQ-035 SHALL, when MEM_REQ_TIMEOUT_EN is defined, count WAIT cycles per beat and, when the count reaches TIMEOUT_CYC with memory_ready still 0, go to RESP with rsp_err=1 and rsp_last=1, aborting the remaining burst.
REQ-036 SHALL, when MEM_REQ_TIMEOUT_EN is defined, give memory_ready priority if it rises on the expiry cycle (normal beat, rsp_err=0).
REQ-037 SHALL, when MEM_REQ_TIMEOUT_EN is undefined, wait in WAIT indefinitely, tie rsp_err to 0, and omit the counter.

Structure
REQ-038 SHALL place the FSM state enum, ADDR_W/DATA_W defaults and the TIMEOUT_CYC default in shared package mem_req_pkg.
REQ-039 SHALL implement the timeout counter as sub-module mem_req_watchdog (clear on SETUP; count in WAIT; expired flag), instantiated only under MEM_REQ_TIMEOUT_EN.

Verification
REQ-040 SHALL cover a single read: addr 0x0010, memory returns 0xBEEF with ready on the first WAIT cycle -> rsp_valid 3 cycles after acceptance, rsp_rdata=0xBEEF, rsp_last=1.
REQ-041 SHALL cover a single write: addr 0x0020, data 0x1234, ready after 4 WAIT cycles -> memory_w=1 and addr/i0 stable for all SETUP+WAIT cycles, then memory_w=0 in IDLE.
REQ-042 SHALL cover a burst read: addr 0, req_len=49 -> 50 rsp_valid pulses, addresses 0..49 issued in order, rsp_last only on the 50th.
REQ-043 SHALL cover a wrap burst: addr 0xFFFE, req_len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 issued, rsp_err=0.
REQ-044 SHALL cover a timeout (with macro, TIMEOUT_CYC=8): memory_ready held 0 -> rsp_valid=1 with rsp_err=1 and rsp_last=1 after 8 WAIT cycles, then IDLE.
REQ-045 SHALL cover reset mid-burst: rst_n low during the 2nd beat WAIT -> all outputs at reset values the same cycle, no rsp_valid, req_ready=1 after release.
